// File: rtl/ahb_master_arbiter.sv
// Two-requester round-robin arbiter feeding one AHB3-Lite master port, one transfer in flight.
// Define AHB_ARB_TIMEOUT_EN to add a data-phase watchdog that aborts after TIMEOUT_CYCLES wait states.
module ahb_master_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                HSEL,
  output logic [ADDR_W-1:0]   HADDR,
  output logic [1:0]          HTRANS,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [2:0]          HBURST,
  output logic [3:0]          HPROT,
  output logic [DATA_W-1:0]   HWDATA,
  input  logic [DATA_W-1:0]   HRDATA,
  input  logic                HREADY,
  input  logic                HRESP
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ADDR   = 2'b01;
  localparam logic [1:0] ST_DATA   = 2'b10;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic              gnt_q, gnt_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              take;
  logic              pick;
  logic              done;
  logic              abort;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // prio_q names the requester that wins a tie; a lone requester always wins.
  always_comb begin
    pick      = (req_valid == 2'b11) ? prio_q : req_valid[1];
    sel_write = pick ? req_write[1] : req_write[0];
    sel_addr  = pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = pick ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  assign take = (state_q == ST_IDLE) && (req_valid != 2'b00);
  assign done = (state_q == ST_DATA) && HREADY;

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive HREADY=0 data-phase cycles; fires on the last allowed one.
  assign abort = (state_q == ST_DATA) && !HREADY &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_DATA) && !HREADY && !abort) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_ADDR;
          gnt_d   = pick;
          prio_d  = ~pick;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        if (done || abort) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= 2'b00;
      if (take) begin
        write_q <= sel_write;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (done || abort) begin
        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
        err_q       <= done ? HRESP : 1'b1;
      end
      // Writes leave the last read data visible.
      if (done && !write_q) begin
        rdata_q <= HRDATA;
      end
    end
  end

  // Grant is combinational in IDLE, masked while reset is held.
  assign req_ready = (take && HRESETn) ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign HSEL   = (state_q == ST_ADDR);
  assign HTRANS = (state_q == ST_ADDR) ? TR_NONSEQ : TR_IDLE;
  assign HADDR  = addr_q;
  assign HWRITE = write_q;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;
  assign HWDATA = wdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: reset values, zero-wait write/read, round-robin,
// wait states, error response, mid-transfer reset and (with AHB_ARB_TIMEOUT_EN) watchdog abort.
module tb_ahb_master_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic                HCLK = 1'b0;
  logic                HRESETn;
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                HSEL;
  logic [ADDR_W-1:0]   HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [2:0]          HBURST;
  logic [3:0]          HPROT;
  logic [DATA_W-1:0]   HWDATA;
  logic [DATA_W-1:0]   HRDATA;
  logic                HREADY;
  logic                HRESP;

  int total = 0;
  int bad   = 0;

  ahb_master_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_write[r] = w;
    req_addr[r*ADDR_W +: ADDR_W] = a;
    req_wdata[r*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; req_valid = 2'b11; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    tick(); tick();
    total++; if ({HSEL, HTRANS, HWRITE} !== 4'b0000) begin bad++; $display("FAIL rst_ctrl got=%b want=0000", {HSEL, HTRANS, HWRITE}); end
    total++; if (HADDR !== 16'h0000) begin bad++; $display("FAIL rst_haddr got=%h want=0000", HADDR); end
    total++; if ({HSIZE, HBURST, HPROT} !== 10'b010_000_0011) begin bad++; $display("FAIL rst_attr got=%b want=0100000011", {HSIZE, HBURST, HPROT}); end
    total++; if (HWDATA !== 32'h0) begin bad++; $display("FAIL rst_hwdata got=%h want=0", HWDATA); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", req_ready); end
    total++; if ({rsp_valid, rsp_err} !== 3'b000) begin bad++; $display("FAIL rst_rsp got=%b want=000", {rsp_valid, rsp_err}); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rsp_rdata); end
    req_valid = 2'b00;
    settle();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 16'h0010, 32'hDEADBEEF);
    req_valid = 2'b01; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h11111111;
    settle();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_grant got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00; settle();
    total++; if ({req_ready, HSEL, HTRANS, HWRITE, HADDR} !== {2'b00, 1'b1, 2'b10, 1'b1, 16'h0010}) begin
      bad++; $display("FAIL wr_addr_phase got=%h want=%h", {req_ready, HSEL, HTRANS, HWRITE, HADDR}, {2'b00, 1'b1, 2'b10, 1'b1, 16'h0010}); end
    tick(); settle();
    total++; if ({HSEL, HTRANS, HWDATA} !== {3'b000, 32'hDEADBEEF}) begin
      bad++; $display("FAIL wr_data_phase got=%h want=%h", {HSEL, HTRANS, HWDATA}, {3'b000, 32'hDEADBEEF}); end
    tick(); settle();
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h0}) begin
      bad++; $display("FAIL wr_rsp got=%h want=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 32'h0}); end
    set_req(0, 1'b0, 16'h0010, 32'h0);
    req_valid = 2'b01; settle();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rd_b2b_grant got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00; settle();
    total++; if ({HTRANS, HWRITE, HADDR} !== {2'b10, 1'b0, 16'h0010}) begin
      bad++; $display("FAIL rd_addr_phase got=%h want=%h", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b0, 16'h0010}); end
    tick(); HRDATA = 32'hDEADBEEF; settle();
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL rd_data_htrans got=%b want=00", HTRANS); end
    tick(); settle();
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'hDEADBEEF}) begin
      bad++; $display("FAIL rd_rsp got=%h want=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 32'hDEADBEEF}); end
    tick(); HRDATA = 32'h55555555; settle();
    total++; if ({rsp_valid, rsp_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      bad++; $display("FAIL rd_hold got=%h want=%h", {rsp_valid, rsp_rdata}, {2'b00, 32'hDEADBEEF}); end
  endtask

  task automatic test_round_robin();
    logic [1:0]        exp_g;
    logic [ADDR_W-1:0] exp_a;
    HRESETn = 1'b0; settle(); tick(); HRESETn = 1'b1;
    set_req(0, 1'b0, 16'h0100, 32'h0);
    set_req(1, 1'b0, 16'h0200, 32'h0);
    HRDATA = 32'hA5A5A5A5; HREADY = 1'b1; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 16'h0100 : 16'h0200;
      settle();
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, req_ready, exp_g); end
      tick(); settle();
      total++; if ({req_ready, HADDR} !== {2'b00, exp_a}) begin
        bad++; $display("FAIL rr_addr%0d got=%h want=%h", k, {req_ready, HADDR}, {2'b00, exp_a}); end
      tick(); settle();
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rr_busy%0d got=%b want=00", k, req_ready); end
      tick(); settle();
      total++; if (rsp_valid !== exp_g) begin bad++; $display("FAIL rr_rsp%0d got=%b want=%b", k, rsp_valid, exp_g); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_wait_states();
    set_req(0, 1'b0, 16'h0020, 32'hCAFEF00D);
    req_valid = 2'b01; HREADY = 1'b1; settle();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL ws_grant got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00; HREADY = 1'b0; settle();
    total++; if ({HTRANS, HADDR} !== {2'b10, 16'h0020}) begin
      bad++; $display("FAIL ws_addr got=%h want=%h", {HTRANS, HADDR}, {2'b10, 16'h0020}); end
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if ({rsp_valid, HADDR, HWDATA} !== {2'b00, 16'h0020, 32'hCAFEF00D}) begin
        bad++; $display("FAIL ws_hold%0d got=%h want=%h", i, {rsp_valid, HADDR, HWDATA}, {2'b00, 16'h0020, 32'hCAFEF00D}); end
      tick();
    end
    HREADY = 1'b1; HRDATA = 32'h12345678;
    tick(); settle();
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h12345678}) begin
      bad++; $display("FAIL ws_rsp got=%h want=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 32'h12345678}); end
  endtask

  task automatic test_error();
    set_req(1, 1'b0, 16'hFFF0, 32'h0);
    req_valid = 2'b10; HREADY = 1'b1; settle();
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL err_grant got=%b want=10", req_ready); end
    tick(); req_valid = 2'b00; HREADY = 1'b0; HRESP = 1'b1;
    tick(); settle();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL err_wait got=%b want=00", rsp_valid); end
    HREADY = 1'b1;
    tick(); settle();
    total++; if ({rsp_valid, rsp_err} !== 3'b101) begin bad++; $display("FAIL err_rsp got=%b want=101", {rsp_valid, rsp_err}); end
    HRESP = 1'b0;
    set_req(1, 1'b1, 16'h0030, 32'h0BADF00D);
    req_valid = 2'b10; settle();
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL err_next_grant got=%b want=10", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); tick(); settle();
    total++; if ({rsp_valid, rsp_err} !== 3'b100) begin bad++; $display("FAIL err_next_rsp got=%b want=100", {rsp_valid, rsp_err}); end
  endtask

  task automatic test_reset_mid();
    set_req(1, 1'b0, 16'h0040, 32'h0);
    req_valid = 2'b10; HREADY = 1'b1; settle();
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL mr_grant got=%b want=10", req_ready); end
    tick(); HREADY = 1'b0;
    tick(); settle();
    total++; if ({HTRANS, rsp_valid} !== 4'b0000) begin bad++; $display("FAIL mr_in_data got=%b want=0000", {HTRANS, rsp_valid}); end
    HRESETn = 1'b0; settle();
    total++; if ({req_ready, HSEL, HTRANS, HWRITE, HADDR} !== 22'h0) begin
      bad++; $display("FAIL mr_ctrl got=%h want=0", {req_ready, HSEL, HTRANS, HWRITE, HADDR}); end
    total++; if ({HWDATA, rsp_rdata, rsp_err} !== 65'h0) begin
      bad++; $display("FAIL mr_data got=%h want=0", {HWDATA, rsp_rdata, rsp_err}); end
    tick(); HREADY = 1'b1; settle();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL mr_norsp1 got=%b want=00", rsp_valid); end
    tick(); settle();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL mr_norsp2 got=%b want=00", rsp_valid); end
    HRESETn = 1'b1; settle();
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL mr_regrant got=%b want=10", req_ready); end
    tick(); req_valid = 2'b00; settle();
    total++; if ({HTRANS, HADDR} !== {2'b10, 16'h0040}) begin
      bad++; $display("FAIL mr_addr got=%h want=%h", {HTRANS, HADDR}, {2'b10, 16'h0040}); end
    tick(); HRDATA = 32'h0F0F0F0F;
    tick(); settle();
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h0F0F0F0F}) begin
      bad++; $display("FAIL mr_rsp got=%h want=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b0, 32'h0F0F0F0F}); end
  endtask

`ifdef AHB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    set_req(0, 1'b0, 16'h0050, 32'h0);
    req_valid = 2'b01; HREADY = 1'b1; settle();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL to_grant got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00; HREADY = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      settle();
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL to_wait%0d got=%b want=00", i, rsp_valid); end
      tick();
    end
    settle();
    total++; if ({rsp_valid, rsp_err} !== 3'b011) begin bad++; $display("FAIL to_abort got=%b want=011", {rsp_valid, rsp_err}); end
    HREADY = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_wait_states();
    test_error();
    test_reset_mid();
`ifdef AHB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
